// File: rtl/avl_slave_mem_responder.sv
// Word-addressed memory responder for i_avl_bus: optional request wait states, credit-gated
// in-order read responses, and a sticky error flag for illegal requests.
module avl_slave_mem_responder #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          RESP_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] address,
    input  logic [3:0]  byte_en,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] write_data,
    output logic        request_ready,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        resp_ready,
    output logic        err
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic              rd_oor_q, rd_oor_d;
    logic              err_q, err_d;
    logic [31:0]       fifo_q [RESP_DEPTH];
    logic [31:0]       fifo_d [RESP_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;

    logic [31:0]       mem [2**AW];
    logic [31:0]       ram_rdata_q;

    logic [31:0]       offset;
    logic              in_range;
    logic [AW-1:0]     word;
    logic              req, accept, rd_acc, wr_acc;
    logic [CW-1:0]     occupancy;
    logic              credit_ok;
    logic [31:0]       ram_out, head;
    logic              push, pop, fifo_pop;

    assign offset    = address - BASE_ADDR;
    assign in_range  = (address >= BASE_ADDR) && ((offset >> (AW + 2)) == 32'd0);
    assign word      = offset[AW+1:2];
    assign req       = read | write;
    assign accept    = req & request_ready;
    // read && write collapses to a read, so the write path never sees that case
    assign rd_acc    = accept & read;
    assign wr_acc    = accept & write & ~read & in_range;
    assign occupancy = CW'(count_q) + CW'(inflight_q);
    assign credit_ok = occupancy < CW'(RESP_DEPTH);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        request_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (WAIT_CYCLES == 0) begin
                    request_ready = credit_ok;
                end else if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'(WAIT_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                request_ready = (cnt_q == 8'd0) && credit_ok;
                if (!req || request_ready) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[word][8*k +: 8] <= write_data[8*k +: 8];
            end
        end
        if (rd_acc) ram_rdata_q <= mem[word];
    end

    // With an empty FIFO the RAM output is presented directly, giving one-cycle latency;
    // it is only pushed if the master does not take it in that same cycle.
    assign ram_out         = rd_oor_q ? 32'h0 : ram_rdata_q;
    assign read_data_valid = (count_q != '0) | inflight_q;
    assign head            = (count_q != '0) ? fifo_q[rd_ptr_q] : ram_out;
    assign read_data       = read_data_valid ? head : 32'h0;
    assign err             = err_q;
    assign pop             = read_data_valid & resp_ready;
    assign fifo_pop        = pop & (count_q != '0);
    assign push            = inflight_q & ~((count_q == '0) & resp_ready);

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = ram_out;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(fifo_pop);
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(fifo_pop);
        inflight_d = rd_acc;
        rd_oor_d   = rd_acc & ~in_range;
        err_d      = err_q | (accept & (~in_range | (read & write)));
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            inflight_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            err_q      <= 1'b0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            rd_oor_q   <= rd_oor_d;
            err_q      <= err_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_avl_slave_mem_responder.sv
// Bench for avl_slave_mem_responder: reference memory model plus response scoreboard on a
// zero-wait instance, and a three-wait-state instance for request_ready timing.
module tb_avl_slave_mem_responder;

    localparam int          AW    = 6;
    localparam int          DEPTH = 2**AW;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] address, write_data, read_data;
    logic [3:0]  byte_en;
    logic        read, write, request_ready, read_data_valid, resp_ready, err;

    logic [31:0] r3_address, r3_write_data, r3_read_data;
    logic [3:0]  r3_byte_en;
    logic        r3_read, r3_write, r3_ready, r3_valid, r3_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_q [$];
    logic        err_exp = 1'b0;

    always #5 clk = ~clk;

    avl_slave_mem_responder #(.AW(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .RESP_DEPTH(4)) dut0 (
        .clk(clk), .rest(rest), .address(address), .byte_en(byte_en), .read(read),
        .write(write), .write_data(write_data), .request_ready(request_ready),
        .read_data(read_data), .read_data_valid(read_data_valid), .resp_ready(resp_ready),
        .err(err));

    avl_slave_mem_responder #(.AW(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .RESP_DEPTH(4)) dut3 (
        .clk(clk), .rest(rest), .address(r3_address), .byte_en(r3_byte_en), .read(r3_read),
        .write(r3_write), .write_data(r3_write_data), .request_ready(r3_ready),
        .read_data(r3_read_data), .read_data_valid(r3_valid), .resp_ready(1'b1),
        .err(r3_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_accept(input logic rd, input logic wr, input logic [31:0] a,
                                         input logic [31:0] wd, input logic [3:0] be);
        logic ok;
        int   w;
        ok = (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
        w  = ok ? int'((a - BASE) >> 2) : 0;
        if (!ok || (rd && wr)) err_exp = 1'b1;
        if (rd) begin
            exp_q.push_back(ok ? mdl[w] : 32'h0);
        end else if (wr && ok) begin
            for (int k = 0; k < 4; k++) if (be[k]) mdl[w][8*k +: 8] = wd[8*k +: 8];
        end
    endfunction

    always @(negedge clk) begin
        if (rest && read_data_valid && resp_ready) begin
            chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("resp_data", read_data, exp_q.pop_front());
        end
    end

    // Called and returns at posedge+1; leaves the request lines driven.
    task automatic bus_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, output int waited);
        read = rd; write = wr; address = a; write_data = wd; byte_en = be;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (request_ready) break;
            waited++;
        end
        if (!request_ready) chk("req_accept", {31'b0, request_ready}, 32'd1);
        else model_accept(rd, wr, a, wd, be);
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        read = 1'b0; write = 1'b0;
    endtask

    task automatic req3(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, output int waited);
        r3_read = rd; r3_write = wr; r3_address = a; r3_write_data = wd; r3_byte_en = be;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (r3_ready) break;
            waited++;
        end
        if (!r3_ready) chk("r3_accept", {31'b0, r3_ready}, 32'd1);
        @(posedge clk); #1;
        r3_read = 1'b0; r3_write = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          n_acc;
        logic [31:0] bp_addr [6];

        rest = 1'b0; read = 0; write = 0; address = 0; write_data = 0; byte_en = 0;
        resp_ready = 1'b1;
        r3_read = 0; r3_write = 0; r3_address = 0; r3_write_data = 0; r3_byte_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, read_data_valid}, 32'd0);
        chk("rst_data", read_data, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        rest = 1'b1;
        @(negedge clk);
        chk("idle_ready_w0", {31'b0, request_ready}, 32'd1);
        chk("idle_ready_w3", {31'b0, r3_ready}, 32'd0);
        @(posedge clk); #1;

        // zero wait states, one-cycle read latency
        bus_req(0, 1, BASE + 32'h10, 32'h1234_5678, 4'hF, w);
        chk("wr_no_wait", w, 0);
        bus_req(1, 0, BASE + 32'h10, 32'h0, 4'h0, w);
        chk("rd_no_wait", w, 0);
        bus_idle();
        @(negedge clk);
        chk("rd_latency_valid", {31'b0, read_data_valid}, 32'd1);
        chk("rd_latency_data", read_data, 32'h1234_5678);
        @(posedge clk); #1;

        // byte lanes, then read-after-write in the very next cycle
        bus_req(0, 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, w);
        bus_req(0, 1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, w);
        bus_req(1, 0, BASE + 32'h20, 32'h0, 4'h0, w);
        bus_idle();
        @(negedge clk);
        chk("byte_lane", read_data, 32'hFFBB_FFDD);
        @(posedge clk); #1;
        bus_req(0, 1, BASE + 32'h24, 32'h0BAD_BEEF, 4'hF, w);
        bus_req(1, 0, BASE + 32'h24, 32'h0, 4'h0, w);
        bus_req(0, 1, BASE + 32'h24, 32'h5555_0000, 4'h0, w);
        bus_req(1, 0, BASE + 32'h24, 32'h0, 4'h0, w);
        bus_idle();
        drain();

        // response credit backpressure
        for (int i = 0; i < 6; i++) begin
            bp_addr[i] = BASE + 32'h40 + 32'(4 * i);
            bus_req(0, 1, bp_addr[i], 32'hA000_0000 + 32'(i * 32'h1111), 4'hF, w);
        end
        bus_idle();
        resp_ready = 1'b0;
        n_acc = 0;
        read = 1'b1; address = bp_addr[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (request_ready && n_acc < 6) begin
                model_accept(1, 0, bp_addr[n_acc], 32'h0, 4'h0);
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc < 6) address = bp_addr[n_acc];
        end
        chk("bp_accepted", n_acc, 4);
        @(negedge clk);
        chk("bp_ready_low", {31'b0, request_ready}, 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && n_acc < 6; c++) begin
            @(negedge clk);
            if (request_ready) begin
                model_accept(1, 0, bp_addr[n_acc], 32'h0, 4'h0);
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc < 6) address = bp_addr[n_acc];
        end
        bus_idle();
        chk("bp_all_accepted", n_acc, 6);
        drain();

        // illegal requests
        chk("err_clean", {31'b0, err}, {31'b0, err_exp});
        bus_req(1, 0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, w);
        bus_idle();
        @(negedge clk);
        chk("oor_read_data", read_data, 32'h0);
        chk("err_oor", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        bus_req(0, 1, BASE - 32'h4, 32'hDEAD_DEAD, 4'hF, w);
        bus_req(1, 1, BASE + 32'h10, 32'h7777_7777, 4'hF, w);
        bus_req(1, 0, BASE + 32'h10, 32'h0, 4'h0, w);
        bus_idle();
        drain();
        chk("err_sticky", {31'b0, err}, {31'b0, err_exp});

        // three wait states on the second instance
        req3(0, 1, BASE + 32'h8, 32'hCAFE_F00D, 4'hF, w);
        chk("w3_write_wait", w, 3);
        req3(1, 0, BASE + 32'h8, 32'h0, 4'h0, w);
        chk("w3_read_wait", w, 3);
        @(negedge clk);
        chk("w3_valid", {31'b0, r3_valid}, 32'd1);
        chk("w3_data", r3_read_data, 32'hCAFE_F00D);
        chk("w3_ready_after", {31'b0, r3_ready}, 32'd0);
        @(posedge clk); #1;
        r3_read = 1'b1; r3_address = BASE + 32'h8;
        @(negedge clk);
        chk("w3_drop_ready0", {31'b0, r3_ready}, 32'd0);
        @(posedge clk); #1;
        r3_read = 1'b0;
        @(negedge clk);
        chk("w3_drop_ready1", {31'b0, r3_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("w3_drop_no_resp", {31'b0, r3_valid}, 32'd0);
        req3(1, 0, BASE + 32'h8, 32'h0, 4'h0, w);
        chk("w3_rewait", w, 3);
        @(negedge clk);
        chk("w3_re_data", r3_read_data, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // reset with three reads outstanding
        resp_ready = 1'b0;
        bus_req(1, 0, BASE + 32'h40, 32'h0, 4'h0, w);
        bus_req(1, 0, BASE + 32'h44, 32'h0, 4'h0, w);
        bus_req(1, 0, BASE + 32'h48, 32'h0, 4'h0, w);
        bus_idle();
        @(posedge clk); #1;
        rest = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, read_data_valid}, 32'd0);
        chk("rst_mid_err", {31'b0, err}, 32'd0);
        exp_q.delete();
        err_exp = 1'b0;
        @(posedge clk); #1;
        rest = 1'b1;
        resp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_stale", {31'b0, read_data_valid}, 32'd0);
        bus_req(1, 0, BASE + 32'h20, 32'h0, 4'h0, w);
        bus_req(1, 0, BASE + 32'h44, 32'h0, 4'h0, w);
        bus_idle();
        @(negedge clk);
        chk("rst_mem_kept", read_data, 32'hA000_1111);
        @(posedge clk); #1;
        drain();
        chk("err_after_rst", {31'b0, err}, {31'b0, err_exp});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
